uart_echo_initiator: RTL and testbench
======================================

UART_ECHO_INITIATOR -- requirements
Module: uart_echo_initiator

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, clk cycles per UART bit (9600 baud at 100 MHz), minimum 4.
REQ-002 SHALL have parameter PAYLOAD_LEN, default 8, payload bytes per frame, range 1-15.
REQ-003 SHALL have parameter TRIGGER_LEN, default 4, trigger bytes sent after the payload, range 1-15.
REQ-004 SHALL have parameter WAKE_BYTE, default 8'h55, byte sent once after reset before the first frame.
REQ-005 SHALL have parameter TRIGGER_BYTE, default 8'hFF, value of every trigger byte.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 32'd2000000, maximum clk cycles allowed between echo bytes.
REQ-007 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-009 SHALL have port start, input, 1, one-cycle pulse that launches a frame.
REQ-010 SHALL have port seed, input, 8, payload base value, sampled on an accepted start.
REQ-011 SHALL have port rx, input, 1, asynchronous serial input, idle high.
REQ-012 SHALL have port tx, output, 1, serial output, idle high.
REQ-013 SHALL have port busy, output, 1, high from accepted start until done.
REQ-014 SHALL have port done, output, 1, one-cycle pulse at frame completion.
REQ-015 SHALL have port pass, output, 1, result of the last frame, held until the next accepted start.
REQ-016 SHALL have port timeout, output, 1, last frame ended by timeout, held until the next accepted start.
REQ-017 SHALL have port err_count, output, 4, mismatched echo bytes in the last frame, saturating at 15.
REQ-018 SHALL have port last_rx, output, 8, most recent byte consumed in RECV.

Function
REQ-019 Line format SHALL be 8N1, LSB first: 1 start bit low, 8 data bits, 1 stop bit high, each exactly CLKS_PER_BIT cycles.
REQ-020 Consecutive transmitted bytes SHALL be back-to-back, with the next start bit in the cycle after the previous stop bit ends.
REQ-021 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-022 The receiver SHALL detect the high-to-low edge, recheck at CLKS_PER_BIT/2 and return to hunt if high, then sample each bit at mid-bit.
REQ-023 The receiver SHALL flag a framing error when the stop-bit sample is low.
REQ-024 The receiver SHALL run continuously; bytes completing outside RECV SHALL be discarded.
REQ-025 The FSM SHALL have states IDLE, WAKE, PAYLOAD, TRIG, RECV, FIN.
REQ-026 In IDLE, start SHALL move to WAKE if the wake byte is not yet sent since reset, else to PAYLOAD.
REQ-027 start SHALL be ignored while busy.
REQ-028 WAKE SHALL send WAKE_BYTE once, set the wake-sent flag, then move to PAYLOAD.
REQ-029 PAYLOAD SHALL send byte k = (seed + k) mod 256 for k = 0..PAYLOAD_LEN-1, then move to TRIG.
REQ-030 TRIG SHALL send TRIGGER_LEN copies of TRIGGER_BYTE.
REQ-031 TRIG SHALL enter RECV in the cycle the stop bit of the final trigger byte begins, so an early echo start bit is not missed.
REQ-032 RECV SHALL consume echo bytes in order and compare echo byte j with (seed + j) mod 256.
REQ-033 A mismatch or framing error SHALL increment err_count.
REQ-034 RECV SHALL move to FIN after PAYLOAD_LEN bytes are consumed.
REQ-035 The timeout counter SHALL reset on RECV entry and on each consumed byte.
REQ-036 If the timeout counter reaches TIMEOUT_CYCLES, the block SHALL set timeout=1 and move to FIN.
REQ-037 FIN SHALL pulse done for one cycle, set pass = (err_count==0 && !timeout), drop busy, then return to IDLE; total one cycle.
REQ-038 An accepted start SHALL clear pass, timeout and err_count in the cycle after start.
REQ-039 A byte completing in the same cycle the timeout counter expires SHALL be consumed, and the timeout SHALL NOT be flagged.

Reset
REQ-040 rst SHALL immediately force the following: tx=1, busy=0, done=0, pass=0, timeout=0, err_count=0, last_rx=0, FSM=IDLE, receiver in hunt, wake-sent flag cleared.
REQ-041 Reset mid-byte SHALL truncate the transmission, with the line held high.
REQ-042 After a reset, the next start SHALL re-send WAKE_BYTE.

Verification
REQ-043 Loopback responder model that echoes the payload after the triggers, CLKS_PER_BIT=16, seed=8'h10 -> tx sends 55, 10..17, FF x4; done after 8 echoes; pass=1, err_count=0, last_rx=8'h17.
REQ-044 Second start with seed=8'hFC and no reset -> no wake byte; payload FC,FD,FE,FF,00,01,02,03 (wrap-around); pass=1.
REQ-045 Responder corrupts echo bytes 2 and 5 -> err_count=2, pass=0, timeout=0.
REQ-046 Responder echoes only 5 bytes, TIMEOUT_CYCLES=1000 -> done 1000 cycles after the 5th byte; timeout=1, pass=0.
REQ-047 Echo byte 3 with its stop bit forced low -> err_count=1.
REQ-048 A 2-cycle low glitch on rx -> no byte received.
REQ-049 start pulsed while busy -> ignored.
REQ-050 rst asserted mid-payload -> tx=1 the same cycle; the next start begins with 55.

Source files
------------

// File: rtl/uart_echo_initiator.sv
// UART echo initiator: sends an optional wake byte, a seeded payload and trigger bytes,
// then checks the echoed payload on rx, with a timeout between echo bytes.
module uart_echo_initiator #(
  parameter int unsigned CLKS_PER_BIT   = 10416,
  parameter int unsigned PAYLOAD_LEN    = 8,
  parameter int unsigned TRIGGER_LEN    = 4,
  parameter logic [7:0]  WAKE_BYTE      = 8'h55,
  parameter logic [7:0]  TRIGGER_BYTE   = 8'hFF,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] seed,
  input  logic       rx,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [3:0] err_count,
  output logic [7:0] last_rx
);

  localparam int unsigned CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0] PL_LAST  = 4'(PAYLOAD_LEN - 1);
  localparam logic [3:0] TL_CNT   = 4'(TRIGGER_LEN);

  typedef enum logic [1:0] {R_HUNT, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [2:0] {S_IDLE, S_WAKE, S_PAYLOAD, S_TRIG, S_RECV, S_FIN} state_e;

  // Receiver: synchronizer, start-bit validation at half bit, mid-bit sampling
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e     r_state_q;
  logic [CW-1:0] r_cnt_q;
  logic [2:0]    r_bit_q;
  logic [7:0]    r_shift_q;
  logic          r_valid_q, r_ferr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      r_state_q <= R_HUNT;
      r_cnt_q   <= '0;
      r_bit_q   <= '0;
      r_shift_q <= '0;
      r_valid_q <= 1'b0;
      r_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      r_valid_q <= 1'b0;
      case (r_state_q)
        R_HUNT: begin
          r_cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) r_state_q <= R_START;
        end
        R_START: begin
          if (r_cnt_q == HALF_M1) begin
            r_cnt_q   <= '0;
            r_bit_q   <= '0;
            r_state_q <= rx_sync_q ? R_HUNT : R_DATA;
          end else r_cnt_q <= r_cnt_q + 1'b1;
        end
        R_DATA: begin
          if (r_cnt_q == BIT_LAST) begin
            r_cnt_q   <= '0;
            r_shift_q <= {rx_sync_q, r_shift_q[7:1]};
            r_bit_q   <= r_bit_q + 1'b1;
            if (r_bit_q == 3'd7) r_state_q <= R_STOP;
          end else r_cnt_q <= r_cnt_q + 1'b1;
        end
        default: begin
          if (r_cnt_q == BIT_LAST) begin
            r_cnt_q   <= '0;
            r_valid_q <= 1'b1;
            r_ferr_q  <= !rx_sync_q;
            r_state_q <= R_HUNT;
          end else r_cnt_q <= r_cnt_q + 1'b1;
        end
      endcase
    end
  end

  // Transmitter: a load on the last stop-bit cycle keeps bytes back-to-back
  logic          t_active_q;
  logic [3:0]    t_bit_q;
  logic [CW-1:0] t_cnt_q;
  logic [8:0]    t_shift_q;
  logic          tx_q;
  logic          t_end_c, stop_begin_c, tx_ready_c, load_c;
  logic [7:0]    load_byte_c;

  state_e        state_q;
  logic [3:0]    idx_q;
  logic [7:0]    seed_q;
  logic          wake_sent_q, busy_q, done_q, pass_q, timeout_q;
  logic [3:0]    err_q;
  logic [7:0]    last_rx_q;
  logic [31:0]   timer_q;

  always_comb begin
    t_end_c      = t_active_q && (t_bit_q == 4'd9) && (t_cnt_q == BIT_LAST);
    stop_begin_c = t_active_q && (t_bit_q == 4'd8) && (t_cnt_q == BIT_LAST);
    tx_ready_c   = !t_active_q || t_end_c;
    load_c       = 1'b0;
    load_byte_c  = TRIGGER_BYTE;
    if (tx_ready_c) begin
      case (state_q)
        S_WAKE:    begin load_c = 1'b1; load_byte_c = WAKE_BYTE; end
        S_PAYLOAD: begin load_c = 1'b1; load_byte_c = seed_q + 8'(idx_q); end
        S_TRIG:    load_c = (idx_q != TL_CNT);
        default:   load_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_active_q <= 1'b0;
      t_bit_q    <= '0;
      t_cnt_q    <= '0;
      t_shift_q  <= '1;
      tx_q       <= 1'b1;
    end else if (load_c) begin
      t_active_q <= 1'b1;
      t_bit_q    <= '0;
      t_cnt_q    <= '0;
      t_shift_q  <= {1'b1, load_byte_c};
      tx_q       <= 1'b0;
    end else if (t_active_q) begin
      if (t_cnt_q == BIT_LAST) begin
        t_cnt_q <= '0;
        if (t_bit_q == 4'd9) begin
          t_active_q <= 1'b0;
          tx_q       <= 1'b1;
        end else begin
          t_bit_q   <= t_bit_q + 1'b1;
          tx_q      <= t_shift_q[0];
          t_shift_q <= {1'b1, t_shift_q[8:1]};
        end
      end else t_cnt_q <= t_cnt_q + 1'b1;
    end
  end

  // Frame sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      seed_q      <= '0;
      wake_sent_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= '0;
      last_rx_q   <= '0;
      timer_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q    <= 1'b1;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            seed_q    <= seed;
            idx_q     <= '0;
            state_q   <= wake_sent_q ? S_PAYLOAD : S_WAKE;
          end
        end
        S_WAKE: begin
          if (load_c) begin
            wake_sent_q <= 1'b1;
            state_q     <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (load_c) begin
            if (idx_q == PL_LAST) begin
              idx_q   <= '0;
              state_q <= S_TRIG;
            end else idx_q <= idx_q + 1'b1;
          end
        end
        S_TRIG: begin
          if (load_c) idx_q <= idx_q + 1'b1;
          else if ((idx_q == TL_CNT) && stop_begin_c) begin
            idx_q   <= '0;
            timer_q <= '0;
            state_q <= S_RECV;
          end
        end
        S_RECV: begin
          // A byte arriving on the expiry cycle wins over the timeout
          if (r_valid_q) begin
            last_rx_q <= r_shift_q;
            timer_q   <= '0;
            if (((r_shift_q != 8'(seed_q + 8'(idx_q))) || r_ferr_q) && (err_q != 4'hF))
              err_q <= err_q + 1'b1;
            if (idx_q == PL_LAST) state_q <= S_FIN;
            else idx_q <= idx_q + 1'b1;
          end else if (timer_q == TIMEOUT_CYCLES - 32'd1) begin
            timeout_q <= 1'b1;
            state_q   <= S_FIN;
          end else timer_q <= timer_q + 32'd1;
        end
        S_FIN: begin
          done_q  <= 1'b1;
          pass_q  <= (err_q == 4'd0) && !timeout_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign err_count = err_q;
  assign last_rx   = last_rx_q;

endmodule

// File: tb/tb_uart_echo_initiator.sv
// Randomized loopback bench for uart_echo_initiator against a frame-level reference model.
module tb_uart_echo_initiator;

  localparam int unsigned CPB = 16;
  localparam int unsigned PL  = 8;
  localparam int unsigned TL  = 4;
  localparam int unsigned TO  = 1000;

  logic       clk = 1'b0;
  logic       rst, start, rx;
  logic [7:0] seed;
  logic       tx, busy, done, pass, timeout;
  logic [3:0] err_count;
  logic [7:0] last_rx;

  uart_echo_initiator #(
    .CLKS_PER_BIT(CPB), .PAYLOAD_LEN(PL), .TRIGGER_LEN(TL),
    .WAKE_BYTE(8'h55), .TRIGGER_BYTE(8'hFF), .TIMEOUT_CYCLES(32'(TO))
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .rx(rx),
    .tx(tx), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .last_rx(last_rx)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] tx_log[$];
  logic [7:0] corrupt[PL];
  bit         stop_bad[PL];
  bit         do_glitch, do_busy_start;
  int unsigned cyc = 0, done_hi = 0, done_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) begin
    done_hi  <= done_hi + 1;
    done_cyc <= cyc;
  end

  // Line monitor: decodes every byte the DUT puts on tx
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && rst === 1'b0) begin
        logic [7:0] b;
        repeat (CPB/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        tx_log.push_back(b);
        repeat (CPB) @(negedge clk);
      end
    end
  end

  task automatic send_rx(input logic [7:0] b, input logic stop_v);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_v;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_start(input logic [7:0] sd);
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seed  = 8'($urandom);
  endtask

  task automatic clear_faults();
    for (int j = 0; j < PL; j++) begin
      corrupt[j]  = 8'h00;
      stop_bad[j] = 1'b0;
    end
    do_glitch     = 1'b0;
    do_busy_start = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] sd, input bit exp_wake, input int n_echo);
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_last;
    int          exp_err, budget, n;
    bit          exp_to;
    int unsigned d0, end_cyc, lat;
    exp_tx = {};
    if (exp_wake) exp_tx.push_back(8'h55);
    for (int k = 0; k < PL; k++) exp_tx.push_back(8'(sd + k));
    for (int k = 0; k < TL; k++) exp_tx.push_back(8'hFF);
    exp_err = 0;
    for (int j = 0; j < n_echo; j++) if (corrupt[j] != 0 || stop_bad[j]) exp_err++;
    if (exp_err > 15) exp_err = 15;
    exp_to   = (n_echo < PL);
    exp_last = 8'(sd + n_echo - 1) ^ corrupt[n_echo - 1];

    tx_log = {};
    d0 = done_hi;
    pulse_start(sd);
    check_eq("busy_after_start", 32'(busy), 32'd1);
    check_eq("pass_cleared", 32'(pass), 32'd0);
    check_eq("err_cleared", 32'(err_count), 32'd0);

    budget = (exp_tx.size() + 2) * 10 * CPB;
    while (tx_log.size() < exp_tx.size() && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("tx_bytes_timely", 32'(budget > 0), 32'd1);
    n = (tx_log.size() < exp_tx.size()) ? tx_log.size() : exp_tx.size();
    for (int i = 0; i < n; i++) check_eq($sformatf("tx_byte%0d", i), 32'(tx_log[i]), 32'(exp_tx[i]));

    // Echo starts as the final trigger's stop bit begins
    repeat (CPB/2) @(negedge clk);
    if (do_glitch) begin
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    for (int j = 0; j < n_echo; j++) begin
      if (j > 0) repeat ($urandom_range(0, 2*CPB) + (stop_bad[j-1] ? CPB : 0)) @(negedge clk);
      if (do_busy_start && j == 3) begin
        check_eq("busy_in_recv", 32'(busy), 32'd1);
        pulse_start(8'(sd + 8'h40));
      end
      send_rx(8'(sd + j) ^ corrupt[j], !stop_bad[j]);
    end
    end_cyc = cyc;

    budget = TO + 20 * CPB;
    while (done_hi == d0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("done_seen", 32'(done_hi != d0), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("done_one_cycle", done_hi - d0, 32'd1);
    if (exp_to) begin
      lat = done_cyc - end_cyc;
      check_eq("timeout_latency", 32'(lat + CPB >= TO && lat <= TO + CPB), 32'd1);
    end
    check_eq("busy_end", 32'(busy), 32'd0);
    check_eq("pass", 32'(pass), 32'(exp_err == 0 && !exp_to));
    check_eq("timeout", 32'(timeout), 32'(exp_to));
    check_eq("err_count", 32'(err_count), 32'(exp_err));
    check_eq("last_rx", 32'(last_rx), 32'(exp_last));
    check_eq("tx_no_extra", tx_log.size(), exp_tx.size());
  endtask

  initial begin
    int budget;
    rst = 1'b1; start = 1'b0; rx = 1'b1; seed = 8'h00;
    clear_faults();
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pass", 32'(pass), 32'd0);
    check_eq("rst_timeout", 32'(timeout), 32'd0);
    check_eq("rst_err", 32'(err_count), 32'd0);
    check_eq("rst_last_rx", 32'(last_rx), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    run_frame(8'h10, 1'b1, PL);
    run_frame(8'hFC, 1'b0, PL);

    clear_faults();
    corrupt[2] = 8'($urandom_range(1, 255));
    corrupt[5] = 8'($urandom_range(1, 255));
    run_frame(8'($urandom), 1'b0, PL);

    clear_faults();
    run_frame(8'($urandom), 1'b0, 5);

    clear_faults();
    stop_bad[3] = 1'b1;
    run_frame(8'($urandom), 1'b0, PL);

    clear_faults();
    do_glitch     = 1'b1;
    do_busy_start = 1'b1;
    run_frame(8'($urandom), 1'b0, PL);

    for (int r = 0; r < 3; r++) begin
      clear_faults();
      for (int j = 0; j < PL; j++) begin
        if ($urandom_range(0, 3) == 0) corrupt[j] = 8'($urandom_range(1, 255));
        if ($urandom_range(0, 7) == 0) stop_bad[j] = 1'b1;
      end
      run_frame(8'($urandom), 1'b0, ($urandom_range(0, 1) == 1) ? PL : int'($urandom_range(1, PL - 1)));
    end

    // Reset in the middle of a payload byte
    clear_faults();
    tx_log = {};
    pulse_start(8'($urandom));
    budget = 6 * 10 * CPB;
    while (tx_log.size() < 2 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    while (tx !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("mid_payload_reached", 32'(budget > 0 && tx === 1'b0), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst_tx", 32'(tx), 32'd1);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_last_rx", 32'(last_rx), 32'd0);
    check_eq("midrst_err", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    check_eq("idle_line_after_rst", 32'(tx), 32'd1);
    run_frame(8'($urandom), 1'b1, PL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
